// File: rtl/flash_read_arbiter_pkg.sv
// rtl/flash_read_arbiter_pkg.sv - shared types and default constants for the flash read arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER
    } state_t;

    typedef enum logic {
        CH_S,
        CH_R
    } channel_t;

    localparam int BMP_WORDS = 7500;
    localparam int FL_ADDR_W = 22;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// rtl/flash_read_arbiter_if.sv - requester and flash port bundle for the flash read arbiter
interface flash_read_arbiter_if #(
    parameter int ADDR_W = flash_arb_pkg::FL_ADDR_W
);
    logic              iStream_Start;
    logic              iS_REQ;
    logic [15:0]       oS_DATA;
    logic              oS_READY;
    logic              oS_FIN;
    logic              iR_REQ;
    logic [ADDR_W-1:0] iR_ADDR;
    logic [15:0]       oR_DATA;
    logic              oR_READY;
    logic              oFL_REQ;
    logic [ADDR_W-1:0] oFL_ADDR;
    logic [15:0]       iFL_DATA;
    logic              iFL_VALID;
    logic              oErr;

    // arbiter side
    modport slave (
        input  iStream_Start, iS_REQ, iR_REQ, iR_ADDR, iFL_DATA, iFL_VALID,
        output oS_DATA, oS_READY, oS_FIN, oR_DATA, oR_READY, oFL_REQ, oFL_ADDR, oErr
    );

    // requesters and flash side
    modport master (
        output iStream_Start, iS_REQ, iR_REQ, iR_ADDR, iFL_DATA, iFL_VALID,
        input  oS_DATA, oS_READY, oS_FIN, oR_DATA, oR_READY, oFL_REQ, oFL_ADDR, oErr
    );
endinterface

// File: rtl/flash_read_arbiter_rr_arb2.sv
// rtl/flash_read_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant memory
module rr_arb2
    import flash_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     req_s,
    input  logic     req_r,
    output logic     grant_valid,
    output channel_t grant
);
    channel_t last_grant;

    // a lone request wins outright; on a tie the channel not served last time wins
    always_comb begin
        grant_valid = en && (req_s || req_r);
        grant       = CH_S;
        if (req_s && req_r) begin
            grant = (last_grant == CH_R) ? CH_S : CH_R;
        end else if (req_r) begin
            grant = CH_R;
        end
    end

    // remember who was served so the next tie goes the other way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= CH_R;
        end else if (grant_valid) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - shares one flash read port between the stream and random readers
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W  = FL_ADDR_W,
    parameter int BASE    = 0,
    parameter int WORDS   = BMP_WORDS,
    parameter int TIMEOUT = 1023
) (
    input  logic                iCLK,
    input  logic                iRST,
    flash_read_arbiter_if.slave bus
);
    localparam int                CNT_W     = $clog2(WORDS + 1);
    localparam int                TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    state_t            state;
    channel_t          cur_ch;
    logic              p_s;
    logic              p_r;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              discard;
    logic [15:0]       fl_data;

    logic              start;
    logic              s_take;
    logic              r_take;
    logic              req_s;
    logic              req_r;
    logic              grant_valid;
    channel_t          grant;
    logic              grant_s;
    logic              grant_r;
    logic [CNT_W-1:0]  cnt_eff;
    logic [ADDR_W-1:0] s_addr;
    logic [ADDR_W-1:0] r_src_addr;
    logic              to_fire;
    logic              retry_s;
    logic              retry_r;
    logic              s_deliver;
    logic              fin_set;

    assign start = bus.iStream_Start;

    // A fresh stream request is accepted after the image is done only if a rewind comes with it.
    assign s_take = bus.iS_REQ && (!bus.oS_FIN || start);
    assign r_take = bus.iR_REQ;

    // The arbiter looks at live pulses as well as held flags so an idle port starts immediately.
    assign req_s = (p_s && !start) || s_take;
    assign req_r = p_r || r_take;

    rr_arb2 u_arb (
        .clk         (iCLK),
        .rst         (iRST),
        .en          (state == IDLE),
        .req_s       (req_s),
        .req_r       (req_r),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign grant_s    = grant_valid && (grant == CH_S);
    assign grant_r    = grant_valid && (grant == CH_R);
    assign cnt_eff    = start ? '0 : word_cnt;
    assign s_addr     = BASE_ADDR + ADDR_W'(cnt_eff);
    assign r_src_addr = p_r ? r_addr : bus.iR_ADDR;

    assign to_fire   = (state == WAIT) && !bus.iFL_VALID && (to_cnt == TO_LAST);
    // A timed-out stream read that was rewound is dropped rather than retried.
    assign retry_s   = to_fire && (cur_ch == CH_S) && !discard && !start;
    assign retry_r   = to_fire && (cur_ch == CH_R);
    assign s_deliver = (state == DELIVER) && (cur_ch == CH_S) && !discard && !start;
    assign fin_set   = s_deliver && (word_cnt == LAST_WORD);

    // Pending flags: a grant consumes one outstanding request; a pulse coinciding with the
    // grant of an already-held request stays pending for the next IDLE.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            p_s    <= 1'b0;
            p_r    <= 1'b0;
            r_addr <= '0;
        end else begin
            if (fin_set) begin
                p_s <= 1'b0;
            end else if (grant_s) begin
                p_s <= p_s && !start && s_take;
            end else begin
                p_s <= (p_s && !start) || s_take || retry_s;
            end

            if (grant_r) begin
                p_r <= p_r && r_take;
            end else begin
                p_r <= p_r || r_take || retry_r;
            end

            if (r_take && (!p_r || grant_r)) begin
                r_addr <= bus.iR_ADDR;
            end else if (retry_r && !p_r) begin
                r_addr <= bus.oFL_ADDR;
            end
        end
    end

    // Transaction FSM with registered flash strobe, delivery pulses and counters.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state        <= IDLE;
            cur_ch       <= CH_S;
            word_cnt     <= '0;
            to_cnt       <= '0;
            discard      <= 1'b0;
            fl_data      <= '0;
            bus.oFL_REQ  <= 1'b0;
            bus.oFL_ADDR <= '0;
            bus.oS_DATA  <= '0;
            bus.oS_READY <= 1'b0;
            bus.oS_FIN   <= 1'b0;
            bus.oR_DATA  <= '0;
            bus.oR_READY <= 1'b0;
            bus.oErr     <= 1'b0;
        end else begin
            bus.oFL_REQ  <= 1'b0;
            bus.oS_READY <= 1'b0;
            bus.oR_READY <= 1'b0;

            if (start) begin
                word_cnt   <= '0;
                bus.oS_FIN <= 1'b0;
            end

            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (grant_valid) begin
                        cur_ch       <= grant;
                        state        <= ISSUE;
                        bus.oFL_REQ  <= 1'b1;
                        bus.oFL_ADDR <= (grant == CH_S) ? s_addr : r_src_addr;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.iFL_VALID) begin
                        fl_data <= bus.iFL_DATA;
                        state   <= DELIVER;
                    end else if (to_fire) begin
                        bus.oErr <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                    if (cur_ch == CH_R) begin
                        bus.oR_DATA  <= fl_data;
                        bus.oR_READY <= 1'b1;
                    end else if (s_deliver) begin
                        bus.oS_DATA  <= fl_data;
                        bus.oS_READY <= 1'b1;
                        word_cnt     <= word_cnt + 1'b1;
                        if (fin_set) begin
                            bus.oS_FIN <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (start && (state != IDLE) && (cur_ch == CH_S)) begin
                discard <= 1'b1;
            end
        end
    end
endmodule
